// File: rtl/axis_arbiter.sv
// ---------------------------------------------------------------------------
// axis_arbiter
//   Merges NUM_STREAMS AXI-Stream slave inputs onto one master output using
//   round-robin arbitration. The output path is a single register stage.
//
//   Optional feature (macro AXIS_ARBITER_PACKET_LOCK_EN):
//     defined   : a grant is held until the beat carrying tlast is accepted,
//                 so packets from different inputs never interleave.
//     undefined : the grant is released after every accepted beat, giving
//                 beat-level round-robin; tlast passes through unchanged.
//
//   Handshake: a beat moves across an interface on a rising clk edge where
//   both tvalid and tready are high. A source holds tvalid and its payload
//   stable until that edge; tready may depend combinationally on state.
//
// Ports
//   clk            sole clock, rising edge
//   sreset         synchronous active-high reset
//   axis_i_tready  per-input ready (bit i -> stream i)
//   axis_i_tvalid  per-input valid
//   axis_i_tlast   per-input last
//   axis_i_tdata   flattened data, stream i at [(i+1)*AXIS_BYTES*8-1 -: AXIS_BYTES*8]
//   axis_i_tuser   flattened user, same slicing with AXIS_USER_BITS
//   axis_o_tready  master ready
//   axis_o_tvalid  master valid
//   axis_o_tlast   master last
//   axis_o_tdata   master data
//   axis_o_tuser   master user
//   axis_o_src     index of the input that sourced the current output beat
// ---------------------------------------------------------------------------
module axis_arbiter #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_STREAMS    = 2,
    localparam int SRC_W = (NUM_STREAMS > 2) ? $clog2(NUM_STREAMS) : 1
) (
    input  logic                                 clk,
    input  logic                                 sreset,
    output logic [NUM_STREAMS-1:0]               axis_i_tready,
    input  logic [NUM_STREAMS-1:0]               axis_i_tvalid,
    input  logic [NUM_STREAMS-1:0]               axis_i_tlast,
    input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0]  axis_i_tdata,
    input  logic [NUM_STREAMS*AXIS_USER_BITS-1:0] axis_i_tuser,
    input  logic                                 axis_o_tready,
    output logic                                 axis_o_tvalid,
    output logic                                 axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]              axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0]            axis_o_tuser,
    output logic [SRC_W-1:0]                     axis_o_src
);

    localparam int DW = AXIS_BYTES * 8;
    localparam int UW = AXIS_USER_BITS;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state;
    // grant doubles as last_grant: it keeps the most recent winner after the
    // grant is released, which is where the next round-robin search starts.
    logic [SRC_W-1:0] grant;

    logic             win_found;
    logic [SRC_W-1:0] win_idx;
    logic [SRC_W-1:0] cand;
    logic             out_free;
    logic             accept;
    logic [DW-1:0]    sel_data;
    logic [UW-1:0]    sel_user;
    logic             sel_last;

    // Round-robin search: first valid input at grant+1, grant+2, ... (mod N).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_STREAMS; k++) begin
            cand = SRC_W'((int'(grant) + k) % NUM_STREAMS);
            if (!win_found && axis_i_tvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The output register can take a new beat when it is empty or draining.
    assign out_free = !axis_o_tvalid || axis_o_tready;

    always_comb begin
        axis_i_tready = '0;
        if (state == ST_GRANT) begin
            axis_i_tready[grant] = out_free;
        end
    end

    assign accept   = (state == ST_GRANT) && axis_i_tvalid[grant] && out_free;
    assign sel_data = axis_i_tdata[grant*DW +: DW];
    assign sel_user = axis_i_tuser[grant*UW +: UW];
    assign sel_last = axis_i_tlast[grant];

    always_ff @(posedge clk) begin
        if (sreset) begin
            state         <= ST_IDLE;
            grant         <= SRC_W'(NUM_STREAMS - 1);
            axis_o_tvalid <= 1'b0;
            axis_o_tlast  <= 1'b0;
            axis_o_tdata  <= '0;
            axis_o_tuser  <= '0;
            axis_o_src    <= '0;
        end else begin
            // Output register: payload only changes when a beat is accepted,
            // so it stays stable while stalled.
            if (accept) begin
                axis_o_tvalid <= 1'b1;
                axis_o_tlast  <= sel_last;
                axis_o_tdata  <= sel_data;
                axis_o_tuser  <= sel_user;
                axis_o_src    <= grant;
            end else if (axis_o_tready) begin
                axis_o_tvalid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        grant <= win_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
`ifdef AXIS_ARBITER_PACKET_LOCK_EN
                    // A granted input that drops tvalid keeps the grant.
                    if (accept && sel_last) begin
                        state <= ST_IDLE;
                    end
`else
                    if (accept) begin
                        state <= ST_IDLE;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_arbiter
//   Directed bench for axis_arbiter with NUM_STREAMS=4, 1-byte data and
//   1-bit user (user = data bit 0). Per-stream source queues feed the DUT;
//   a packet-level round-robin model fills the expected queue, and a compare
//   process checks every output transfer, output stability under stall and
//   the input-ready gating rule on every cycle.
// ---------------------------------------------------------------------------
module tb_axis_arbiter;

    localparam int NS = 4;
    localparam int DW = 8;
    localparam int UW = 1;
    localparam int SW = 2;
    localparam int EW = SW + 1 + UW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic sreset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NS-1:0]    axis_i_tready;
    logic [NS-1:0]    axis_i_tvalid;
    logic [NS-1:0]    axis_i_tlast;
    logic [NS*DW-1:0] axis_i_tdata;
    logic [NS*UW-1:0] axis_i_tuser;
    logic             axis_o_tready;
    logic             axis_o_tvalid;
    logic             axis_o_tlast;
    logic [DW-1:0]    axis_o_tdata;
    logic [UW-1:0]    axis_o_tuser;
    logic [SW-1:0]    axis_o_src;

    axis_arbiter #(
        .AXIS_BYTES    (1),
        .AXIS_USER_BITS(UW),
        .NUM_STREAMS   (NS)
    ) dut (
        .clk          (clk),
        .sreset       (sreset),
        .axis_i_tready(axis_i_tready),
        .axis_i_tvalid(axis_i_tvalid),
        .axis_i_tlast (axis_i_tlast),
        .axis_i_tdata (axis_i_tdata),
        .axis_i_tuser (axis_i_tuser),
        .axis_o_tready(axis_o_tready),
        .axis_o_tvalid(axis_o_tvalid),
        .axis_o_tlast (axis_o_tlast),
        .axis_o_tdata (axis_o_tdata),
        .axis_o_tuser (axis_o_tuser),
        .axis_o_src   (axis_o_src)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         src_q[NS][$];   // beats still to be offered by each source
    beat_t         mdl_in[NS][$];  // model copy of what each source was given
    logic [EW-1:0] exp_q[$];       // {src, last, user, data}
    int            mdl_last;
    logic [NS-1:0] mask;           // forces a source's tvalid low

    logic [DW-1:0] log_data[$];
    logic [SW-1:0] log_src[$];
    logic          log_last[$];
    int            log_cyc[$];

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef AXIS_ARBITER_PACKET_LOCK_EN
    int e33_src[5] = '{0, 0, 1, 1, 2};
    int e35_src[4] = '{0, 0, 0, 1};
`else
    int e33_src[5] = '{0, 1, 2, 3, 0};
    int e35_src[4] = '{0, 1, 0, 1};
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- model ----------------
    // Serves non-empty sources round-robin from mdl_last+1; a unit is a
    // whole packet with packet lock, otherwise a single beat.
    task automatic mdl_run();
        bit any;
        int idx;
        beat_t b;
        forever begin
            any = 0;
            idx = 0;
            for (int k = 1; k <= NS; k++) begin
                if (!any && mdl_in[(mdl_last + k) % NS].size() > 0) begin
                    any = 1;
                    idx = (mdl_last + k) % NS;
                end
            end
            if (!any) break;
`ifdef AXIS_ARBITER_PACKET_LOCK_EN
            do begin
                b = mdl_in[idx].pop_front();
                exp_q.push_back({SW'(idx), b.last, b.data[0], b.data});
            end while (!b.last && mdl_in[idx].size() > 0);
`else
            b = mdl_in[idx].pop_front();
            exp_q.push_back({SW'(idx), b.last, b.data[0], b.data});
`endif
            mdl_last = idx;
        end
    endtask

    task automatic load_pkt(input int s, input logic [DW-1:0] base, input int n);
        beat_t b;
        for (int j = 0; j < n; j++) begin
            b.data = base + DW'(j);
            b.last = (j == n - 1);
            src_q[s].push_back(b);
            mdl_in[s].push_back(b);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            mdl_in[i].delete();
        end
        exp_q.delete();
        mask = '0;
        mdl_last = NS - 1;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_src.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    // ---------------- driver ----------------
    task automatic drive_inputs();
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0 && !mask[i]) begin
                axis_i_tvalid[i]          = 1'b1;
                axis_i_tlast[i]           = src_q[i][0].last;
                axis_i_tdata[i*DW +: DW]  = src_q[i][0].data;
                axis_i_tuser[i*UW +: UW]  = src_q[i][0].data[0];
            end else begin
                axis_i_tvalid[i]          = 1'b0;
                axis_i_tlast[i]           = 1'b0;
                axis_i_tdata[i*DW +: DW]  = '0;
                axis_i_tuser[i*UW +: UW]  = '0;
            end
        end
    endtask

    initial begin
        logic [NS-1:0] fire_s;
        axis_i_tvalid = '0;
        axis_i_tlast  = '0;
        axis_i_tdata  = '0;
        axis_i_tuser  = '0;
        forever begin
            @(negedge clk);
            fire_s = axis_i_tvalid & axis_i_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++)
                if (fire_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            drive_inputs();
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic          stall_prev;
        logic [EW-1:0] prev_out;
        logic [EW-1:0] cur_out;
        logic [EW-1:0] exp_v;
        stall_prev = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (sreset) begin
                stall_prev = 1'b0;
            end else begin
                cur_out = {axis_o_src, axis_o_tlast, axis_o_tuser, axis_o_tdata};
                check("tready_onehot", 32'($countones(axis_i_tready) <= 1), 32'd1);
                if (|axis_i_tready)
                    check("tready_gate", 32'(!axis_o_tvalid || axis_o_tready), 32'd1);
                if (stall_prev) begin
                    check("stall_valid", 32'(axis_o_tvalid), 32'd1);
                    check("stall_stable", 32'(cur_out), 32'(prev_out));
                end
                if (axis_o_tvalid && axis_o_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(cur_out), 32'hFFFF_FFFF);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("beat", 32'(cur_out), 32'(exp_v));
                    end
                    log_data.push_back(axis_o_tdata);
                    log_src.push_back(axis_o_src);
                    log_last.push_back(axis_o_tlast);
                    log_cyc.push_back(cyc);
                end
                stall_prev = axis_o_tvalid && !axis_o_tready;
                prev_out   = cur_out;
            end
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic reset_dut();
        @(negedge clk);
        sreset = 1'b1;
        axis_o_tready = 1'b1;
        clear_all();
        repeat (2) @(negedge clk);
        check("rst_o_tvalid", 32'(axis_o_tvalid), 32'd0);
        check("rst_o_tlast", 32'(axis_o_tlast), 32'd0);
        check("rst_i_tready", 32'(axis_i_tready), 32'd0);
        check("rst_o_tdata", 32'(axis_o_tdata), 32'd0);
        check("rst_o_tuser", 32'(axis_o_tuser), 32'd0);
        check("rst_o_src", 32'(axis_o_src), 32'd0);
        sreset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Waits (at posedge+2) until the output holds the given data while valid.
    task automatic wait_out_data(input logic [DW-1:0] d, input int budget);
        int n = 0;
        bit seen = 0;
        while (!seen && n < budget) begin
            @(posedge clk);
            #2;
            seen = axis_o_tvalid && (axis_o_tdata == d);
            n++;
        end
        check("wait_out_data", 32'(seen), 32'd1);
    endtask

    // ---------------- tests ----------------
    initial begin
        int c0;
        int n;
        int max_gap;
        sreset = 1'b1;
        axis_o_tready = 1'b1;
        mask = '0;
        mdl_last = NS - 1;

        // 3-beat packet on stream 0: latency and back-to-back timing.
        reset_dut();
        clear_log();
        load_pkt(0, 8'hA1, 3);
        mdl_run();
        @(posedge clk);
        #1;
        c0 = cyc;
        wait_drain(60);
        check("t1_count", 32'(log_data.size()), 32'd3);
        check("t1_d0", 32'(log_data[0]), 32'hA1);
        check("t1_d1", 32'(log_data[1]), 32'hA2);
        check("t1_d2", 32'(log_data[2]), 32'hA3);
        check("t1_src", 32'(log_src[0]), 32'd0);
        check("t1_last0", 32'(log_last[0]), 32'd0);
        check("t1_last2", 32'(log_last[2]), 32'd1);
        check("t1_lat", 32'(log_cyc[0] - c0), 32'd2);
`ifdef AXIS_ARBITER_PACKET_LOCK_EN
        check("t1_c1", 32'(log_cyc[1] - c0), 32'd3);
        check("t1_c2", 32'(log_cyc[2] - c0), 32'd4);
`else
        check("t1_c1", 32'(log_cyc[1] - c0), 32'd4);
        check("t1_c2", 32'(log_cyc[2] - c0), 32'd6);
`endif

        // All four streams with two 2-beat packets each.
        reset_dut();
        clear_log();
        for (int s = 0; s < NS; s++) begin
            load_pkt(s, DW'((s + 1) * 16), 2);
            load_pkt(s, DW'((s + 1) * 16 + 8), 2);
        end
        mdl_run();
        wait_drain(300);
        check("t2_count", 32'(log_data.size()), 32'd16);
        for (int k = 0; k < 5; k++) check("t2_src_order", 32'(log_src[k]), 32'(e33_src[k]));
        check("t2_d0", 32'(log_data[0]), 32'h10);
`ifdef AXIS_ARBITER_PACKET_LOCK_EN
        check("t2_inpkt_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
        check("t2_bubble", 32'(log_cyc[2] - log_cyc[1]), 32'd2);
        check("t2_d2", 32'(log_data[2]), 32'h20);
`else
        check("t2_gap01", 32'(log_cyc[1] - log_cyc[0]), 32'd2);
        check("t2_gap12", 32'(log_cyc[2] - log_cyc[1]), 32'd2);
        check("t2_d1", 32'(log_data[1]), 32'h20);
`endif

        // Sink stall of 5 cycles mid-packet on stream 1.
        reset_dut();
        clear_log();
        load_pkt(1, 8'h50, 4);
        mdl_run();
        wait_out_data(8'h51, 60);
        axis_o_tready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("t3_hold_data", 32'(axis_o_tdata), 32'h51);
            check("t3_hold_src", 32'(axis_o_src), 32'd1);
            check("t3_hold_valid", 32'(axis_o_tvalid), 32'd1);
            check("t3_i_tready", 32'(axis_i_tready), 32'd0);
        end
        @(posedge clk);
        #1;
        axis_o_tready = 1'b1;
        wait_drain(60);
        check("t3_count", 32'(log_data.size()), 32'd4);
        check("t3_d3", 32'(log_data[3]), 32'h53);

        // Streams 0 and 1 competing.
        reset_dut();
        clear_log();
        load_pkt(0, 8'h60, 3);
        load_pkt(1, 8'h70, 3);
        mdl_run();
        wait_drain(100);
        check("t4_count", 32'(log_data.size()), 32'd6);
        for (int k = 0; k < 4; k++) check("t4_src_order", 32'(log_src[k]), 32'(e35_src[k]));

        // Granted source drops tvalid mid-packet for 3 cycles.
        reset_dut();
        clear_log();
        load_pkt(2, 8'h80, 6);
        mdl_run();
        wait_out_data(8'h81, 60);
        mask[2] = 1'b1;
`ifdef AXIS_ARBITER_PACKET_LOCK_EN
        // A competitor arriving during the gap must wait for the packet end.
        load_pkt(0, 8'h90, 2);
        mdl_run();
`endif
        repeat (3) @(posedge clk);
        #2;
        mask[2] = 1'b0;
        wait_drain(100);
        max_gap = 0;
        for (int k = 1; k < log_cyc.size(); k++)
            if (log_cyc[k] - log_cyc[k-1] > max_gap) max_gap = log_cyc[k] - log_cyc[k-1];
        check("t5_gap_seen", 32'(max_gap >= 3), 32'd1);
        check("t5_d5", 32'(log_data[5]), 32'h85);

        // Reset pulse while beat 2 of a 4-beat packet on stream 2 is out.
        reset_dut();
        clear_log();
        load_pkt(2, 8'hB0, 4);
        mdl_run();
        n = 0;
        while (log_data.size() < 2 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t6_reached_beat2", 32'(log_data.size()), 32'd2);
        sreset = 1'b1;
        clear_all();
        @(posedge clk);
        #1;
        sreset = 1'b0;
        @(negedge clk);
        #1;
        check("t6_o_tvalid", 32'(axis_o_tvalid), 32'd0);
        check("t6_i_tready", 32'(axis_i_tready), 32'd0);
        check("t6_o_tdata", 32'(axis_o_tdata), 32'd0);
        load_pkt(3, 8'hC0, 1);
        mdl_run();
        wait_drain(60);
        check("t6_count", 32'(log_data.size()), 32'd3);
        check("t6_src", 32'(log_src[2]), 32'd3);
        check("t6_data", 32'(log_data[2]), 32'hC0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1);
    end

endmodule
